// File: rtl/axi_burst_master.sv
// AXI burst master / traffic generator: one write or read burst per command,
// data pattern seed+beat, read data checked against the same pattern.
module axi_burst_master #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 4,
   parameter int TIMEOUT    = 256
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [LEN_WIDTH-1:0]    cmd_len,
   input  logic [1:0]              cmd_burst,
   input  logic [DATA_WIDTH-1:0]   cmd_seed,
   output logic                    busy,
   output logic                    done,
   output logic [7:0]              err_mismatch_cnt,
   output logic                    err_resp,
   output logic                    err_timeout,
   output logic                    err_cmd,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic [LEN_WIDTH-1:0]    awlen,
   output logic [2:0]              awsize,
   output logic [1:0]              awburst,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wlast,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic [LEN_WIDTH-1:0]    arlen,
   output logic [2:0]              arsize,
   output logic [1:0]              arburst,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp,
   input  logic                    rlast,
   input  logic                    rvalid,
   output logic                    rready
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WADDR, S_WDATA, S_WRESP, S_RADDR, S_RDATA, S_DONE
   } state_t;

   state_t                  r_state, w_next;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [LEN_WIDTH-1:0]    r_len;
   logic [LEN_WIDTH-1:0]    r_beat;
   logic [1:0]              r_burst;
   logic [DATA_WIDTH-1:0]   r_seed;
   logic [TW-1:0]           r_tmo_cnt;
   logic [7:0]              r_mm_cnt;
   logic                    r_err_resp, r_err_timeout, r_err_cmd;

   logic                    w_accept, w_illegal, w_wrap_len_ok;
   logic                    w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_hs;
   logic                    w_active, w_tmo, w_beat_last;
   logic [DATA_WIDTH-1:0]   w_pattern;

   assign w_accept      = (r_state == S_IDLE) && cmd_valid;
   assign w_wrap_len_ok = (32'(cmd_len) == 32'd1) || (32'(cmd_len) == 32'd3) ||
                          (32'(cmd_len) == 32'd7) || (32'(cmd_len) == 32'd15);
   assign w_illegal     = (cmd_burst == 2'b11) || ((cmd_burst == 2'b10) && !w_wrap_len_ok);

   assign w_aw_hs = (r_state == S_WADDR) && awready;
   assign w_w_hs  = (r_state == S_WDATA) && wready;
   assign w_b_hs  = (r_state == S_WRESP) && bvalid;
   assign w_ar_hs = (r_state == S_RADDR) && arready;
   assign w_r_hs  = (r_state == S_RDATA) && rvalid;
   assign w_hs    = w_aw_hs || w_w_hs || w_b_hs || w_ar_hs || w_r_hs;

   assign w_active    = (r_state != S_IDLE) && (r_state != S_DONE);
   assign w_tmo       = w_active && !w_hs && (r_tmo_cnt == TW'(TIMEOUT - 1));
   assign w_beat_last = (r_beat == r_len);
   assign w_pattern   = r_seed + DATA_WIDTH'(r_beat);

   // NOTE: every valid/ready is decoded from the state register, so an abort or
   // reset that leaves a state drops the handshake signals on that same edge.
   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);
   assign awvalid   = (r_state == S_WADDR);
   assign wvalid    = (r_state == S_WDATA);
   assign wlast     = (r_state == S_WDATA) && w_beat_last;
   assign bready    = (r_state == S_WRESP);
   assign arvalid   = (r_state == S_RADDR);
   assign rready    = (r_state == S_RDATA);

   assign awaddr  = r_addr;
   assign awlen   = r_len;
   assign awburst = r_burst;
   assign awsize  = 3'($clog2(DATA_WIDTH / 8));
   assign araddr  = r_addr;
   assign arlen   = r_len;
   assign arburst = r_burst;
   assign arsize  = 3'($clog2(DATA_WIDTH / 8));
   assign wdata   = w_pattern;
   assign wstrb   = '1;

   assign err_mismatch_cnt = r_mm_cnt;
   assign err_resp         = r_err_resp;
   assign err_timeout      = r_err_timeout;
   assign err_cmd          = r_err_cmd;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (cmd_valid) w_next = w_illegal ? S_DONE : (cmd_write ? S_WADDR : S_RADDR);
         S_WADDR: if (w_aw_hs) w_next = S_WDATA;
         S_WDATA: if (w_w_hs && w_beat_last) w_next = S_WRESP;
         S_WRESP: if (w_b_hs) w_next = S_DONE;
         S_RADDR: if (w_ar_hs) w_next = S_RDATA;
         S_RDATA: if (w_r_hs && rlast) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (w_tmo) w_next = S_DONE;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state       <= S_IDLE;
         r_addr        <= '0;
         r_len         <= '0;
         r_beat        <= '0;
         r_burst       <= '0;
         r_seed        <= '0;
         r_tmo_cnt     <= '0;
         r_mm_cnt      <= '0;
         r_err_resp    <= 1'b0;
         r_err_timeout <= 1'b0;
         r_err_cmd     <= 1'b0;
      end else begin
         r_state <= w_next;
         if ((w_next != r_state) || w_hs) r_tmo_cnt <= '0;
         else if (w_active)               r_tmo_cnt <= r_tmo_cnt + 1'b1;

         if (w_accept) begin
            r_addr        <= cmd_addr;
            r_len         <= cmd_len;
            r_burst       <= cmd_burst;
            r_seed        <= cmd_seed;
            r_beat        <= '0;
            r_mm_cnt      <= '0;
            r_err_resp    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_cmd     <= w_illegal;
         end
         if (w_w_hs || w_r_hs) r_beat <= r_beat + 1'b1;
         if (w_b_hs && (bresp != 2'b00)) r_err_resp <= 1'b1;

         // A burst-length disagreement is just rlast differing from "beat == len".
         if (w_r_hs) begin
            if ((rresp != 2'b00) || (rlast != w_beat_last)) r_err_resp <= 1'b1;
            if ((rdata != w_pattern) && (r_mm_cnt != 8'hFF)) r_mm_cnt <= r_mm_cnt + 1'b1;
         end
         if (w_tmo) r_err_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_axi_burst_master.sv
// Scoreboard bench for axi_burst_master: directed commands push expected W beats,
// address phases and done-status into queues; a monitor pops and compares.
module tb_axi_burst_master;
   localparam int AW = 4, DW = 32, LW = 4, TMO = 256;

   logic          aclk = 1'b0, areset;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [LW-1:0] cmd_len;
   logic [1:0]    cmd_burst;
   logic [DW-1:0] cmd_seed;
   logic          busy, done, err_resp, err_timeout, err_cmd;
   logic [7:0]    err_mismatch_cnt;
   logic [AW-1:0] awaddr, araddr;
   logic [LW-1:0] awlen, arlen;
   logic [2:0]    awsize, arsize;
   logic [1:0]    awburst, arburst, bresp, rresp;
   logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rlast, rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [DW/8-1:0] wstrb;

   axi_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT(TMO)) dut (
      .aclk(aclk), .areset(areset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst),
      .cmd_seed(cmd_seed), .busy(busy), .done(done), .err_mismatch_cnt(err_mismatch_cnt),
      .err_resp(err_resp), .err_timeout(err_timeout), .err_cmd(err_cmd),
      .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready)
   );

   always #5 aclk = ~aclk;

   typedef struct packed { logic [DW-1:0] data; logic last; } w_exp_t;
   typedef struct packed { logic [AW-1:0] addr; logic [LW-1:0] len; logic [1:0] burst; } a_exp_t;
   typedef struct packed { logic [7:0] mm; logic resp; logic tmo; logic cmd; } d_exp_t;

   w_exp_t exp_w[$];
   a_exp_t exp_aw[$], exp_ar[$];
   d_exp_t exp_d[$];

   int n_cmp = 0, n_fail = 0;
   int n_awv = 0, n_wv = 0;

   // slave configuration
   logic          cfg_awready = 1'b1;
   logic          cfg_wpat[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
   logic [1:0]    cfg_bresp = 2'b00;
   logic [DW-1:0] cfg_rd[16];
   int            cfg_nbeats = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reactive slave: looks at handshakes before the edge, drives after it.
   initial begin : slave
      logic lw, bh, ah, rh, r_act;
      int   widx, ridx;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
      rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
      r_act = 0; widx = 0; ridx = 0;
      forever begin
         @(negedge aclk);
         lw = wvalid && wready && wlast;
         bh = bvalid && bready;
         ah = arvalid && arready;
         rh = rvalid && rready;
         @(posedge aclk); #1;
         if (areset) begin
            r_act = 0; widx = 0; ridx = 0;
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
         end else begin
            if (lw) bvalid = 1'b1;
            if (bh) bvalid = 1'b0;
            bresp = cfg_bresp;
            if (ah) begin r_act = 1; ridx = 0; end
            else if (rh) begin
               ridx++;
               if (ridx >= cfg_nbeats) r_act = 0;
            end
            rvalid  = r_act;
            rdata   = cfg_rd[ridx % 16];
            rlast   = r_act && (ridx == cfg_nbeats - 1);
            awready = cfg_awready;
            arready = 1'b1;
            if (wvalid) begin wready = cfg_wpat[widx % 4]; widx++; end
            else begin wready = 1'b0; widx = 0; end
         end
      end
   end

   // Monitor: compares every presented output against the head of its queue.
   initial begin : monitor
      w_exp_t we;
      a_exp_t ae;
      d_exp_t de;
      forever begin
         @(negedge aclk);
         if (!areset) begin
            if (awvalid) n_awv++;
            if (awvalid && awready) begin
               if (exp_aw.size() == 0) check("aw_unexpected", exp_aw.size(), 1);
               else begin
                  ae = exp_aw.pop_front();
                  check("awaddr", awaddr, ae.addr);
                  check("awlen", awlen, ae.len);
                  check("awburst", awburst, ae.burst);
               end
            end
            if (wvalid) begin
               n_wv++;
               if (exp_w.size() == 0) check("w_unexpected", exp_w.size(), 1);
               else begin
                  we = exp_w[0];
                  check("wdata", wdata, we.data);
                  check("wlast", wlast, we.last);
                  if (wready) void'(exp_w.pop_front());
               end
            end
            if (arvalid && arready) begin
               if (exp_ar.size() == 0) check("ar_unexpected", exp_ar.size(), 1);
               else begin
                  ae = exp_ar.pop_front();
                  check("araddr", araddr, ae.addr);
                  check("arlen", arlen, ae.len);
                  check("arburst", arburst, ae.burst);
               end
            end
            if (done) begin
               if (exp_d.size() == 0) check("done_unexpected", exp_d.size(), 1);
               else begin
                  de = exp_d.pop_front();
                  check("err_mismatch_cnt", err_mismatch_cnt, de.mm);
                  check("err_resp", err_resp, de.resp);
                  check("err_timeout", err_timeout, de.tmo);
                  check("err_cmd", err_cmd, de.cmd);
               end
            end
         end
      end
   end

   task automatic exp_write(input [AW-1:0] a, input [LW-1:0] l, input [1:0] b,
                            input [DW-1:0] s, input logic resp);
      for (int k = 0; k <= int'(l); k++) exp_w.push_back('{data: s + DW'(k), last: (k == int'(l))});
      exp_aw.push_back('{addr: a, len: l, burst: b});
      exp_d.push_back('{mm: 8'd0, resp: resp, tmo: 1'b0, cmd: 1'b0});
   endtask

   task automatic issue(input logic wr, input [AW-1:0] a, input [LW-1:0] l,
                        input [1:0] b, input [DW-1:0] s);
      for (int i = 0; i < 50 && !cmd_ready; i++) begin @(posedge aclk); #1; end
      if (!cmd_ready) check("cmd_ready_wait", cmd_ready, 1);
      cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_burst = b; cmd_seed = s;
      @(posedge aclk); #1;
      cmd_valid = 0;
   endtask

   task automatic wait_done(input int budget, input string name);
      logic got = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge aclk);
         if (done) begin got = 1; break; end
      end
      check({name, "_done_seen"}, got, 1);
      if (got) check({name, "_cmd_ready_in_done"}, cmd_ready, 0);
      @(posedge aclk); #1;
      check({name, "_cmd_ready_after"}, cmd_ready, 1);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic got;
      areset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_burst = 0; cmd_seed = 0;
      for (int i = 0; i < 16; i++) cfg_rd[i] = 0;
      repeat (3) @(posedge aclk);
      #1;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valids", {awvalid, wvalid, wlast, bready, arvalid, rready}, 6'b0);
      check("rst_errs", {err_mismatch_cnt, err_resp, err_timeout, err_cmd}, 11'b0);
      check("rst_addr", {awaddr, awlen, awburst, araddr, arlen, arburst}, 0);
      check("rst_wdata", wdata, 0);
      check("awsize", awsize, 3'd2);
      check("wstrb", wstrb, 4'hF);
      areset = 0;
      @(posedge aclk); #1;

      // write INCR addr1 len3 seed5, no backpressure
      exp_write(4'd1, 4'd3, 2'b01, 32'd5, 1'b0);
      n_wv = 0;
      issue(1, 4'd1, 4'd3, 2'b01, 32'd5);
      check("awvalid_after_accept", awvalid, 1);
      check("busy_after_accept", busy, 1);
      wait_done(50, "wr_incr");
      check("wr_incr_wvalid_cycles", n_wv, 4);

      // read INCR, clean data
      for (int k = 0; k < 4; k++) cfg_rd[k] = 32'd5 + k;
      cfg_nbeats = 4;
      exp_ar.push_back('{addr: 4'd1, len: 4'd3, burst: 2'b01});
      exp_d.push_back('{mm: 8'd0, resp: 1'b0, tmo: 1'b0, cmd: 1'b0});
      issue(0, 4'd1, 4'd3, 2'b01, 32'd5);
      check("arvalid_after_accept", arvalid, 1);
      wait_done(50, "rd_ok");

      // read with beat 2 corrupted
      cfg_rd[2] = 0;
      exp_ar.push_back('{addr: 4'd1, len: 4'd3, burst: 2'b01});
      exp_d.push_back('{mm: 8'd1, resp: 1'b0, tmo: 1'b0, cmd: 1'b0});
      issue(0, 4'd1, 4'd3, 2'b01, 32'd5);
      wait_done(50, "rd_mm");

      // read with early rlast (2 beats for len 3)
      cfg_rd[2] = 32'd7;
      cfg_nbeats = 2;
      exp_ar.push_back('{addr: 4'd2, len: 4'd3, burst: 2'b01});
      exp_d.push_back('{mm: 8'd0, resp: 1'b1, tmo: 1'b0, cmd: 1'b0});
      issue(0, 4'd2, 4'd3, 2'b01, 32'd5);
      wait_done(50, "rd_short");

      // illegal WRAP len 6
      n_awv = 0;
      exp_d.push_back('{mm: 8'd0, resp: 1'b0, tmo: 1'b0, cmd: 1'b1});
      issue(1, 4'd0, 4'd6, 2'b10, 32'd0);
      check("illegal_done_now", done, 1);
      check("illegal_err_cmd", err_cmd, 1);
      check("illegal_awvalid", awvalid, 0);
      wait_done(5, "illegal");
      check("illegal_awvalid_cycles", n_awv, 0);

      // legal WRAP len 7
      n_wv = 0;
      exp_write(4'd0, 4'd7, 2'b10, 32'h10, 1'b0);
      issue(1, 4'd0, 4'd7, 2'b10, 32'h10);
      wait_done(60, "wrap8");
      check("wrap8_wvalid_cycles", n_wv, 8);

      // bad write response
      cfg_bresp = 2'b10;
      exp_write(4'd3, 4'd0, 2'b00, 32'd9, 1'b1);
      issue(1, 4'd3, 4'd0, 2'b00, 32'd9);
      wait_done(30, "bresp");
      cfg_bresp = 2'b00;

      // AW timeout
      cfg_awready = 0;
      n_awv = 0;
      exp_d.push_back('{mm: 8'd0, resp: 1'b0, tmo: 1'b1, cmd: 1'b0});
      issue(1, 4'd4, 4'd0, 2'b01, 32'd0);
      wait_done(400, "timeout");
      check("timeout_awvalid_cycles", n_awv, TMO);
      check("timeout_awvalid_low", awvalid, 0);
      cfg_awready = 1;

      // wready 1,0,0,1 with seed wrap-around
      cfg_wpat = '{1'b1, 1'b0, 1'b0, 1'b1};
      n_wv = 0;
      exp_write(4'd0, 4'd1, 2'b01, 32'hFFFF_FFFF, 1'b0);
      issue(1, 4'd0, 4'd1, 2'b01, 32'hFFFF_FFFF);
      wait_done(50, "stall");
      check("stall_wvalid_cycles", n_wv, 4);
      cfg_wpat = '{1'b1, 1'b1, 1'b1, 1'b1};

      // reset during WDATA beat 1
      exp_write(4'd5, 4'd3, 2'b01, 32'h100, 1'b0);
      issue(1, 4'd5, 4'd3, 2'b01, 32'h100);
      got = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge aclk);
         if (wvalid && wdata == 32'h101) begin got = 1; break; end
      end
      check("rst_mid_beat1_seen", got, 1);
      areset = 1;
      @(posedge aclk); #1;
      check("rst_mid_valids", {awvalid, wvalid, wlast, bready, arvalid, rready}, 6'b0);
      check("rst_mid_cmd_ready", cmd_ready, 1);
      check("rst_mid_errs", {err_mismatch_cnt, err_resp, err_timeout, err_cmd}, 11'b0);
      check("rst_mid_wdata", wdata, 0);
      exp_w.delete(); exp_aw.delete(); exp_d.delete();
      areset = 0;
      @(posedge aclk); #1;

      // normal read after reset
      for (int k = 0; k < 4; k++) cfg_rd[k] = 32'd5 + k;
      cfg_nbeats = 4;
      exp_ar.push_back('{addr: 4'd1, len: 4'd3, burst: 2'b01});
      exp_d.push_back('{mm: 8'd0, resp: 1'b0, tmo: 1'b0, cmd: 1'b0});
      issue(0, 4'd1, 4'd3, 2'b01, 32'd5);
      wait_done(50, "rd_after_rst");

      repeat (2) @(posedge aclk);
      #1;
      check("left_w", exp_w.size(), 0);
      check("left_aw", exp_aw.size(), 0);
      check("left_ar", exp_ar.size(), 0);
      check("left_done", exp_d.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
